// File: rtl/logic_sweep_pkg.sv
// Shared types and constants for the logic sweep controller and its settle timer.
package logic_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCapture,
        StDone
    } sweep_state_e;

    localparam int unsigned MAX_SETTLE_CYCLES = 15;
    localparam int unsigned SETTLE_CNT_W      = 4;

    // One signature bit per {sel, a, b} combination.
    function automatic int unsigned res_width(input int unsigned sel_w);
        return 32'd1 << (sel_w + 2);
    endfunction

endpackage

// File: rtl/logic_sweep_controller_settle_timer.sv
// Loadable down-counter that flags terminal count; clear has priority over load.
module settle_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/logic_sweep_controller.sv
// Walks {sel, a, b} through every combination, samples y_in after a settle interval
// and compares the packed truth-table signature against an expected value.
module logic_sweep_controller
    import logic_sweep_pkg::*;
#(
    parameter int unsigned SEL_W         = 3,
    parameter int unsigned SETTLE_CYCLES = 2,
    localparam int unsigned RES_W        = res_width(SEL_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [RES_W-1:0] exp_sig,
    input  logic             y_in,
    output logic             a_out,
    output logic             b_out,
    output logic [SEL_W-1:0] sel_out,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             result_valid,
    output logic             pass
);

    localparam int unsigned IDX_W = SEL_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RES_W - 1);
    // Timer holds SETTLE for SETTLE_CYCLES-1 cycles; CAPTURE supplies the last one.
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 1) ? SETTLE_CNT_W'(SETTLE_CYCLES - 2) : '0;
    localparam bit HAS_SETTLE = (SETTLE_CYCLES > 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > MAX_SETTLE_CYCLES) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range");
    end

    sweep_state_e     state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [RES_W-1:0] result_q, result_d;
    logic [RES_W-1:0] exp_q, exp_d;
    logic             valid_q, valid_d;
    logic             pass_q, pass_d;
    logic             tmr_load, tmr_clr, tmr_tc;

    settle_timer #(
        .CNT_W (SETTLE_CNT_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_LOAD),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        result_d = result_q;
        exp_d    = exp_q;
        valid_d  = valid_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_clr  = 1'b0;

        if (abort && state_q != StIdle) begin
            state_d  = StIdle;
            k_d      = '0;
            result_d = '0;
            valid_d  = 1'b0;
            pass_d   = 1'b0;
            tmr_clr  = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        exp_d    = exp_sig;
                        result_d = '0;
                        valid_d  = 1'b0;
                        pass_d   = 1'b0;
                        k_d      = '0;
                        if (HAS_SETTLE) begin
                            state_d  = StSettle;
                            tmr_load = 1'b1;
                        end else begin
                            state_d = StCapture;
                        end
                    end
                end
                StSettle: begin
                    if (tmr_tc) begin
                        state_d = StCapture;
                    end
                end
                StCapture: begin
                    result_d[k_q] = y_in;
                    if (k_q == LAST_IDX) begin
                        state_d = StDone;
                        k_d     = '0;
                        valid_d = 1'b1;
                        pass_d  = (result_d == exp_q);
                    end else begin
                        k_d = k_q + IDX_W'(1);
                        if (HAS_SETTLE) begin
                            state_d  = StSettle;
                            tmr_load = 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            k_q      <= '0;
            result_q <= '0;
            exp_q    <= '0;
            valid_q  <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            result_q <= result_d;
            exp_q    <= exp_d;
            valid_q  <= valid_d;
            pass_q   <= pass_d;
        end
    end

    // k_q is forced to zero outside a sweep, so the stimulus is taken straight from it.
    assign b_out        = k_q[0];
    assign a_out        = k_q[1];
    assign sel_out      = k_q[IDX_W-1:2];
    assign busy         = (state_q == StSettle) || (state_q == StCapture);
    assign done         = (state_q == StDone);
    assign result       = result_q;
    assign result_valid = valid_q;
    assign pass         = pass_q;

endmodule

// File: tb/tb_logic_sweep_controller.sv
// Randomised bench for logic_sweep_controller: two instances (settle 2 and 1) checked every
// cycle against a time-based behavioural model, plus literal expectations.
module tb_logic_sweep_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] exp_sig = '0;
    int          mode = 0;
    logic [31:0] lut = '0;

    logic        y_in   [2];
    logic        a_o    [2];
    logic        b_o    [2];
    logic [2:0]  sel_o  [2];
    logic        d_busy [2];
    logic        d_done [2];
    logic [31:0] d_res  [2];
    logic        d_rv   [2];
    logic        d_pass [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // y source: 0 = A, 1 = B, 2 = A&B, 3 = configurable_logic model, 4 = random LUT.
    function automatic logic yf(input int m, input logic [4:0] k, input logic [31:0] l);
        logic a, b;
        a = k[1];
        b = k[0];
        case (m)
            0: return a;
            1: return b;
            2: return a & b;
            3: case (k[4:2])
                3'd0: return a & b;
                3'd1: return a | b;
                3'd2: return a ^ b;
                3'd3: return ~(a & b);
                3'd4: return ~(a | b);
                3'd5: return ~(a ^ b);
                3'd6: return a;
                default: return ~b;
            endcase
            default: return l[k];
        endcase
    endfunction

    function automatic logic [31:0] tbl(input int m, input logic [31:0] l);
        logic [31:0] t;
        for (int k = 0; k < 32; k++) t[k] = yf(m, 5'(k), l);
        return t;
    endfunction

    assign y_in[0] = yf(mode, {sel_o[0], a_o[0], b_o[0]}, lut);
    assign y_in[1] = yf(mode, {sel_o[1], a_o[1], b_o[1]}, lut);

    logic_sweep_controller #(
        .SEL_W         (3),
        .SETTLE_CYCLES (2)
    ) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .exp_sig      (exp_sig),
        .y_in         (y_in[0]),
        .a_out        (a_o[0]),
        .b_out        (b_o[0]),
        .sel_out      (sel_o[0]),
        .busy         (d_busy[0]),
        .done         (d_done[0]),
        .result       (d_res[0]),
        .result_valid (d_rv[0]),
        .pass         (d_pass[0])
    );

    logic_sweep_controller #(
        .SEL_W         (3),
        .SETTLE_CYCLES (1)
    ) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .exp_sig      (exp_sig),
        .y_in         (y_in[1]),
        .a_out        (a_o[1]),
        .b_out        (b_o[1]),
        .sel_out      (sel_o[1]),
        .busy         (d_busy[1]),
        .done         (d_done[1]),
        .result       (d_res[1]),
        .result_valid (d_rv[1]),
        .pass         (d_pass[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a sweep is just a cycle count t since the start edge.
    logic        m_busy [2];
    logic        m_done [2];
    logic        m_rv   [2];
    logic        m_pass [2];
    int unsigned m_t    [2];
    logic [31:0] m_res  [2];
    logic [31:0] m_exp  [2];

    function automatic int unsigned s_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic model_clear(input int i);
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_rv[i]   = 1'b0;
        m_pass[i] = 1'b0;
        m_t[i]    = 0;
        m_res[i]  = '0;
        m_exp[i]  = '0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) model_clear(i);
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    model_clear(i);
                end else if (m_busy[i]) begin
                    if (abort) begin
                        m_busy[i] = 1'b0;
                        m_res[i]  = '0;
                        m_rv[i]   = 1'b0;
                        m_pass[i] = 1'b0;
                    end else begin
                        if (m_t[i] % s_of(i) == s_of(i) - 1)
                            m_res[i][m_t[i] / s_of(i)] = yf(mode, 5'(m_t[i] / s_of(i)), lut);
                        m_t[i]++;
                        if (m_t[i] == 32 * s_of(i)) begin
                            m_busy[i] = 1'b0;
                            m_done[i] = 1'b1;
                            m_rv[i]   = 1'b1;
                            m_pass[i] = (m_res[i] == m_exp[i]);
                        end
                    end
                end else if (m_done[i]) begin
                    m_done[i] = 1'b0;
                    if (abort) begin
                        m_res[i]  = '0;
                        m_rv[i]   = 1'b0;
                        m_pass[i] = 1'b0;
                    end
                end else if (start && !abort) begin
                    m_busy[i] = 1'b1;
                    m_t[i]    = 0;
                    m_exp[i]  = exp_sig;
                    m_res[i]  = '0;
                    m_rv[i]   = 1'b0;
                    m_pass[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic [4:0] k;
                k = m_busy[i] ? 5'(m_t[i] / s_of(i)) : 5'd0;
                chk($sformatf("u%0d.busy", i), 64'(d_busy[i]), 64'(m_busy[i]));
                chk($sformatf("u%0d.done", i), 64'(d_done[i]), 64'(m_done[i]));
                chk($sformatf("u%0d.stim", i), 64'({sel_o[i], a_o[i], b_o[i]}), 64'(k));
                chk($sformatf("u%0d.result", i), 64'(d_res[i]), 64'(m_res[i]));
                chk($sformatf("u%0d.result_valid", i), 64'(d_rv[i]), 64'(m_rv[i]));
                chk($sformatf("u%0d.pass", i), 64'(d_pass[i]), 64'(m_pass[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] e);
        exp_sig = e;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int i, output int cyc);
        cyc = 0;
        while (d_done[i] !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        if (d_done[i] !== 1'b1) chk($sformatf("u%0d.done_timeout", i), 64'(0), 64'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((d_busy[0] || d_busy[1] || d_done[0] || d_done[1]) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("idle_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        int  cyc;
        int  pre;
        logic saw;

        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic saw;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.reset_ctl", i),
                64'({d_busy[i], d_done[i], d_rv[i], d_pass[i], sel_o[i], a_o[i], b_o[i]}), 64'(0));
            chk($sformatf("u%0d.reset_res", i), 64'(d_res[i]), 64'(0));
        end
        rst_n = 1'b1;
        tick();

        // Y tied to A
        mode = 0;
        pulse_start(32'hCCCC_CCCC);
        wait_done(0, cyc);
        chk("tieA.latency", 64'(cyc), 64'(64));
        chk("tieA.result", 64'(d_res[0]), 64'(32'hCCCC_CCCC));
        chk("tieA.pass", 64'(d_pass[0]), 64'(1));
        tick();
        chk("tieA.done_one_cycle", 64'(d_done[0]), 64'(0));
        wait_idle();

        // Y tied to B
        mode = 1;
        pulse_start(32'hCCCC_CCCC);
        wait_done(0, cyc);
        chk("tieB.result", 64'(d_res[0]), 64'(32'hAAAA_AAAA));
        chk("tieB.pass", 64'(d_pass[0]), 64'(0));
        chk("tieB.valid", 64'(d_rv[0]), 64'(1));
        wait_idle();

        // configurable_logic model
        mode = 3;
        pulse_start(tbl(3, '0));
        wait_done(0, cyc);
        chk("cfg.pass", 64'(d_pass[0]), 64'(1));
        wait_idle();

        // Abort at k=17
        mode = 4;
        lut  = $urandom;
        pulse_start($urandom);
        repeat (34) tick();
        chk("abort.k17", 64'({sel_o[0], a_o[0], b_o[0]}), 64'(17));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort.busy", 64'(d_busy[0]), 64'(0));
        chk("abort.result", 64'(d_res[0]), 64'(0));
        chk("abort.valid", 64'(d_rv[0]), 64'(0));
        saw = 1'b0;
        repeat (70) begin
            tick();
            if (d_done[0]) saw = 1'b1;
        end
        chk("abort.no_done", 64'(saw), 64'(0));
        wait_idle();
        mode = 3;
        pulse_start(tbl(3, '0));
        wait_done(0, cyc);
        chk("after_abort.latency", 64'(cyc), 64'(64));
        chk("after_abort.pass", 64'(d_pass[0]), 64'(1));
        wait_idle();

        // start while busy is ignored
        mode = 0;
        pulse_start(32'h0);
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(0, cyc);
        chk("busy_start.latency", 64'(cyc + 11), 64'(64));
        wait_idle();

        // abort + start together in IDLE
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start.busy0", 64'(d_busy[0]), 64'(0));
        chk("abort_start.busy1", 64'(d_busy[1]), 64'(0));
        tick();

        // SETTLE_CYCLES=1 with A&B
        mode = 2;
        pulse_start(32'h8888_8888);
        wait_done(1, cyc);
        chk("s1.latency", 64'(cyc), 64'(32));
        chk("s1.result", 64'(d_res[1]), 64'(32'h8888_8888));
        chk("s1.pass", 64'(d_pass[1]), 64'(1));
        wait_idle();

        // Randomised sweeps with stray starts and occasional aborts
        for (int it = 0; it < 25; it++) begin
            wait_idle();
            mode = $urandom_range(0, 4);
            lut  = $urandom;
            pulse_start(($urandom_range(0, 1) == 1) ? tbl(mode, lut) : $urandom);
            for (int c = 0; c < 80; c++) begin
                start = ($urandom_range(0, 39) == 0);
                abort = ($urandom_range(0, 59) == 0);
                exp_sig = $urandom;
                tick();
            end
            start = 1'b0;
            abort = 1'b0;
        end
        wait_idle();

        // Reset mid-sweep at k=10
        mode = 4;
        pulse_start($urandom);
        repeat (20) tick();
        chk("rst.k10", 64'({sel_o[0], a_o[0], b_o[0]}), 64'(10));
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.rst_async_ctl", i),
                64'({d_busy[i], d_done[i], d_rv[i], d_pass[i], sel_o[i], a_o[i], b_o[i]}), 64'(0));
            chk($sformatf("u%0d.rst_async_res", i), 64'(d_res[i]), 64'(0));
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst.busy_after", 64'(d_busy[0]), 64'(0));
        chk("rst.valid_after", 64'(d_rv[0]), 64'(0));
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
